// File: rtl/wb_mailbox_pkg.sv
// wb_mailbox_pkg: shared constants for the Wishbone inter-core mailbox.
// Holds the register offsets (adr[3:2]), STATUS/CTRL bit positions, the
// Wishbone CTI/BTE codes the slave decodes and the handshake FSM encoding.
package wb_mailbox_pkg;

  // Register offsets, word index within a mailbox's 16-byte window
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DROP   = 2'd3;

  // STATUS fields: [15:0] count
  localparam int unsigned STATUS_EMPTY_BIT = 16;
  localparam int unsigned STATUS_FULL_BIT  = 17;

  // CTRL fields
  localparam int unsigned CTRL_IRQ_EN_BIT = 0;
  localparam int unsigned CTRL_FLUSH_BIT  = 1;

  // Wishbone B3 cycle type / burst type codes
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Handshake FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RESP  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  function automatic logic [31:0] pack_status(input logic [15:0] count, input logic empty,
                                              input logic full);
    logic [31:0] s;
    s = '0;
    s[15:0] = count;
    s[STATUS_EMPTY_BIT] = empty;
    s[STATUS_FULL_BIT] = full;
    return s;
  endfunction

endpackage

// File: rtl/wb_mailbox_fifo.sv
// wb_mailbox_fifo: one mailbox word FIFO.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, pop_i      write/read strobes; ignored when full/empty
//   flush_i            empties the FIFO in one cycle (has priority)
//   wdata_i            word to push
//   rdata_o            head word (valid when not empty)
//   count_o            words held, 0..DEPTH
//   empty_o, full_o    occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wb_mailbox_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW:0]  wptr_q, rptr_q;
  logic [31:0]  mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[PW-1:0]];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_i) begin
      rptr_q <= wptr_q;
    end else begin
      if (do_push) wptr_q <= wptr_q + {{PW{1'b0}}, 1'b1};
      if (do_pop)  rptr_q <= rptr_q + {{PW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: only words between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[PW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/wb_mailbox.sv
// wb_mailbox: Wishbone B3 slave giving each core a hardware message FIFO.
// Any master pushes into any mailbox; core n pops mailbox n and sees irq_o[n]
// while its mailbox is non-empty and its irq_en bit is set.
// Per-mailbox map (mailbox = adr[AW-1:4]): 0x0 DATA, 0x4 STATUS, 0x8 CTRL, 0xC DROP.
// Ports:
//   wb_clk_i, wb_rst_ni     clock, asynchronous active-low reset
//   wb_adr_i..wb_bte_i      Wishbone B3 slave inputs (sel ignored, full-word only)
//   wb_dat_o, wb_ack_o,
//   wb_err_o, wb_rty_o      registered-feedback termination (rty tied low)
//   irq_o                   per-core level interrupt
// Build option: define WB_MAILBOX_DROP_STATS_EN for per-mailbox 16-bit
// saturating clear-on-read counters of pushes rejected while full (DROP).
module wb_mailbox
  import wb_mailbox_pkg::*;
#(
  parameter int unsigned NUM_CORES = 1,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AW        = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic [AW-1:0]        wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  input  logic [3:0]           wb_sel_i,
  input  logic                 wb_we_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic [2:0]           wb_cti_i,
  input  logic [1:0]           wb_bte_i,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic                 wb_rty_o,
  output logic [NUM_CORES-1:0] irq_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned MW = AW - 4;

  // Address decode
  logic [1:0]           reg_sel;
  logic [MW-1:0]        mbox_sel;
  logic                 mbox_ok;
  logic [NUM_CORES-1:0] hit;

  assign reg_sel  = wb_adr_i[3:2];
  assign mbox_sel = wb_adr_i[AW-1:4];
  assign mbox_ok  = 32'(mbox_sel) < NUM_CORES;

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) hit[i] = (32'(mbox_sel) == i);
  end

  // Mailbox FIFOs
  logic [31:0]          fifo_rdata [NUM_CORES];
  logic [PW:0]          fifo_count [NUM_CORES];
  logic [NUM_CORES-1:0] fifo_empty, fifo_full;
  logic [NUM_CORES-1:0] irq_en_q;
  logic                 push_any, pop_any, ctrl_wr, drop_rd, push_rej;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_mbox
    wb_mailbox_fifo #(
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk_i  (wb_clk_i),
      .rst_ni (wb_rst_ni),
      .push_i (push_any & hit[i]),
      .pop_i  (pop_any & hit[i]),
      .flush_i(ctrl_wr & hit[i] & wb_dat_i[CTRL_FLUSH_BIT]),
      .wdata_i(wb_dat_i),
      .rdata_o(fifo_rdata[i]),
      .count_o(fifo_count[i]),
      .empty_o(fifo_empty[i]),
      .full_o (fifo_full[i])
    );
  end

  // Fields of the addressed mailbox
  logic [31:0] sel_rdata;
  logic [PW:0] sel_count;
  logic        sel_empty, sel_full, sel_irq_en;
  logic [15:0] sel_drop;

  always_comb begin
    sel_rdata  = '0;
    sel_count  = '0;
    sel_empty  = 1'b1;
    sel_full   = 1'b0;
    sel_irq_en = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (hit[i]) begin
        sel_rdata  = fifo_rdata[i];
        sel_count  = fifo_count[i];
        sel_empty  = fifo_empty[i];
        sel_full   = fifo_full[i];
        sel_irq_en = irq_en_q[i];
      end
    end
  end

  // Handshake: a beat is accepted unless the previous one is being terminated
  // without continuation.
  logic [1:0]  state_q, state_d;
  logic        ack_q, err_q;
  logic [31:0] dat_q;
  logic        accept, cont;
  logic        do_err;
  logic [31:0] rd_data;

  assign accept = wb_cyc_i & wb_stb_i & (state_q != ST_RESP);
  assign cont   = (wb_cti_i == CTI_INC) && (wb_bte_i == BTE_LINEAR);

  always_comb begin
    do_err   = 1'b0;
    rd_data  = '0;
    push_any = 1'b0;
    pop_any  = 1'b0;
    ctrl_wr  = 1'b0;
    drop_rd  = 1'b0;
    push_rej = 1'b0;
    if (accept) begin
      if (!mbox_ok) begin
        do_err = 1'b1;
      end else begin
        unique case (reg_sel)
          REG_DATA: begin
            if (wb_we_i) begin
              if (sel_full) begin
                do_err   = 1'b1;
                push_rej = 1'b1;
              end else begin
                push_any = 1'b1;
              end
            end else if (sel_empty) begin
              do_err = 1'b1;
            end else begin
              pop_any = 1'b1;
              rd_data = sel_rdata;
            end
          end
          REG_STATUS: begin
            if (!wb_we_i) rd_data = pack_status(16'(sel_count), sel_empty, sel_full);
          end
          REG_CTRL: begin
            if (wb_we_i) ctrl_wr = 1'b1;
            else         rd_data[CTRL_IRQ_EN_BIT] = sel_irq_en;
          end
          REG_DROP: begin
            if (!wb_we_i) begin
              drop_rd       = 1'b1;
              rd_data[15:0] = sel_drop;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = cont ? ST_BURST : ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      ST_BURST: begin
        if (!wb_cyc_i)            state_d = ST_IDLE;
        else if (accept && !cont) state_d = ST_RESP;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= ST_IDLE;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= '0;
      irq_en_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= accept & ~do_err;
      err_q   <= accept & do_err;
      dat_q   <= rd_data;
      if (ctrl_wr) begin
        irq_en_q <= (irq_en_q & ~hit) | (hit & {NUM_CORES{wb_dat_i[CTRL_IRQ_EN_BIT]}});
      end
    end
  end

`ifdef WB_MAILBOX_DROP_STATS_EN
  logic [15:0] drop_q [NUM_CORES];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int unsigned i = 0; i < NUM_CORES; i++) drop_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        // Clear-on-read; a rejection in the same cycle lands in the fresh value.
        if (hit[i] && drop_rd) begin
          drop_q[i] <= push_rej ? 16'd1 : 16'd0;
        end else if (hit[i] && push_rej && (drop_q[i] != 16'hffff)) begin
          drop_q[i] <= drop_q[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    sel_drop = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) if (hit[i]) sel_drop = drop_q[i];
  end
`else
  logic unused_drop;
  assign sel_drop    = '0;
  assign unused_drop = drop_rd ^ push_rej;
`endif

  // Dropping cyc mid-burst suppresses the in-flight termination.
  assign wb_ack_o = ack_q & wb_cyc_i;
  assign wb_err_o = err_q & wb_cyc_i;
  assign wb_dat_o = dat_q;
  assign wb_rty_o = 1'b0;
  assign irq_o    = ~fifo_empty & irq_en_q;

  logic unused_in;
  assign unused_in = ^{wb_sel_i, wb_adr_i[1:0]};

endmodule

// File: tb/tb_wb_mailbox.sv
// tb_wb_mailbox: self-checking bench for wb_mailbox (NUM_CORES=2, DEPTH=8, AW=8).
// A queue-based model predicts every termination, read word and irq_o; a
// negedge process compares the DUT against it each cycle, and directed
// sequences add literal expectations.
module tb_wb_mailbox;
  localparam int NC = 2;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [7:0]    wb_adr = '0;
  logic [31:0]   wb_dat_w = '0;
  logic [3:0]    wb_sel = 4'hf;
  logic          wb_we = 1'b0;
  logic          wb_cyc = 1'b0;
  logic          wb_stb = 1'b0;
  logic [2:0]    wb_cti = '0;
  logic [1:0]    wb_bte = '0;
  logic [31:0]   wb_dat_r;
  logic          wb_ack, wb_err, wb_rty;
  logic [NC-1:0] irq;

  wb_mailbox #(
    .NUM_CORES(NC),
    .DEPTH    (DEPTH),
    .AW       (8)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wb_adr_i (wb_adr),
    .wb_dat_i (wb_dat_w),
    .wb_sel_i (wb_sel),
    .wb_we_i  (wb_we),
    .wb_cyc_i (wb_cyc),
    .wb_stb_i (wb_stb),
    .wb_cti_i (wb_cti),
    .wb_bte_i (wb_bte),
    .wb_dat_o (wb_dat_r),
    .wb_ack_o (wb_ack),
    .wb_err_o (wb_err),
    .wb_rty_o (wb_rty),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  logic [31:0] mq [NC][$];
  bit          men [NC];
  int unsigned mdrop [NC];

  bit          exp_v = 0;
  bit          e_ack, e_err, e_chk;
  logic [31:0] e_dat;

  function automatic logic [NC-1:0] model_irq();
    logic [NC-1:0] r;
    for (int i = 0; i < NC; i++) r[i] = men[i] && (mq[i].size() != 0);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      mq[i].delete();
      men[i] = 0;
      mdrop[i] = 0;
    end
  endtask

  task automatic model_beat(input bit w, input logic [7:0] a, input logic [31:0] d);
    int mb = int'(a[7:4]);
    int rg = int'(a[3:2]);
    e_ack = 0; e_err = 0; e_chk = 0; e_dat = '0;
    if (mb >= NC) begin
      e_err = 1;
      return;
    end
    case (rg)
      0: begin
        if (w) begin
          if (mq[mb].size() == DEPTH) begin
            e_err = 1;
            if (mdrop[mb] < 65535) mdrop[mb]++;
          end else begin
            mq[mb].push_back(d);
            e_ack = 1;
          end
        end else begin
          e_chk = 1;
          if (mq[mb].size() == 0) e_err = 1;
          else begin
            e_ack = 1;
            e_dat = mq[mb].pop_front();
          end
        end
      end
      1: begin
        e_ack = 1;
        if (!w) begin
          e_chk = 1;
          e_dat = 32'(mq[mb].size());
          e_dat[16] = (mq[mb].size() == 0);
          e_dat[17] = (mq[mb].size() == DEPTH);
        end
      end
      2: begin
        e_ack = 1;
        if (w) begin
          men[mb] = d[0];
          if (d[1]) mq[mb].delete();
        end else begin
          e_chk = 1;
          e_dat = {31'b0, men[mb]};
        end
      end
      default: begin
        e_ack = 1;
        if (!w) begin
          e_chk = 1;
`ifdef WB_MAILBOX_DROP_STATS_EN
          e_dat = mdrop[mb];
          mdrop[mb] = 0;
`else
          e_dat = '0;
`endif
        end
      end
    endcase
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("ack", {31'b0, wb_ack}, {31'b0, exp_v & e_ack});
      check("err", {31'b0, wb_err}, {31'b0, exp_v & e_err});
      if (exp_v && e_chk) check("rdata", wb_dat_r, e_dat);
      check("irq", {30'b0, irq}, {30'b0, model_irq()});
      check("rty", {31'b0, wb_rty}, 32'd0);
    end
  end

  logic [2:0]  cti_tab [4] = '{3'b000, 3'b111, 3'b001, 3'b011};
  logic [31:0] last_dat;
  bit          last_ack, last_err;
  logic [31:0] burst_rd [$];
  int          burst_acks;

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    exp_v = 0;
    #1;
  endtask

  task automatic classic(input bit w, input logic [7:0] a, input logic [31:0] d);
    int r = int'($urandom_range(0, 4));
    wb_cyc = 1; wb_stb = 1; wb_we = w; wb_adr = a; wb_dat_w = d;
    if (r == 4) begin
      wb_cti = 3'b010;
      wb_bte = 2'($urandom_range(1, 3));
    end else begin
      wb_cti = cti_tab[r];
      wb_bte = 2'($urandom_range(0, 3));
    end
    @(posedge clk);
    model_beat(w, a, d);
    exp_v = 1;
    @(negedge clk);
    last_dat = wb_dat_r; last_ack = wb_ack; last_err = wb_err;
    @(posedge clk);
    exp_v = 0;
    #1;
    wb_cyc = 0; wb_stb = 0;
  endtask

  // mode 0: normal; 1: drop cyc after beat k is accepted; 2: async reset after beat k
  task automatic burst(input bit w, input logic [7:0] base, input bit inc, input int n,
                       input bit waits, input logic [31:0] seed, input int mode, input int k);
    int i = 0;
    burst_rd.delete();
    burst_acks = 0;
    wb_cyc = 1; wb_stb = 1; wb_we = w; wb_bte = 2'b00;
    wb_adr = base; wb_dat_w = seed;
    wb_cti = (n == 1) ? 3'b111 : 3'b010;
    while (i < n) begin
      @(posedge clk);
      if (wb_stb) begin
        model_beat(w, wb_adr, wb_dat_w);
        exp_v = 1;
        i++;
        if (mode == 1 && i == k) begin
          exp_v = 0;
          #1;
          wb_cyc = 0; wb_stb = 0;
          tick();
          return;
        end
        if (mode == 2 && i == k) begin
          #3;
          rst_n = 0;
          model_reset();
          exp_v = 0;
          wb_cyc = 0; wb_stb = 0;
          #1;
          check("rst_ack", {31'b0, wb_ack}, 32'd0);
          check("rst_irq", {30'b0, irq}, 32'd0);
          check("rst_dat", wb_dat_r, 32'd0);
          tick();
          tick();
          rst_n = 1;
          return;
        end
      end else begin
        exp_v = 0;
      end
      #1;
      if (i < n) begin
        wb_stb = !(waits && ($urandom_range(0, 2) == 0));
        wb_adr = inc ? 8'(int'(base) + 4 * i) : base;
        wb_dat_w = seed + 32'(i);
        wb_cti = (i == n - 1) ? 3'b111 : 3'b010;
      end
      @(negedge clk);
      if (wb_ack) burst_acks++;
      if (exp_v && !w && wb_ack) burst_rd.push_back(wb_dat_r);
    end
    @(posedge clk);
    exp_v = 0;
    #1;
    wb_cyc = 0; wb_stb = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1 rst_n = 0;
    #2;
    check("reset_ack", {31'b0, wb_ack}, 32'd0);
    check("reset_err", {31'b0, wb_err}, 32'd0);
    check("reset_dat", wb_dat_r, 32'd0);
    check("reset_irq", {30'b0, irq}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    tick();

    // Classic write, STATUS, irq enable
    classic(1, 8'h00, 32'hDEADBEEF);
    check("wr_ack", {31'b0, last_ack}, 32'd1);
    classic(0, 8'h04, 32'h0);
    check("status_one", last_dat, 32'h0000_0001);
    check("irq_before_en", {30'b0, irq}, 32'd0);
    classic(1, 8'h08, 32'h1);
    check("irq_after_en", {30'b0, irq}, 32'd1);
    classic(0, 8'h00, 32'h0);
    check("pop_deadbeef", last_dat, 32'hDEADBEEF);

    // Fill mbox1 by burst, overflow
    burst(1, 8'h10, 0, 8, 0, 32'h100, 0, 0);
    check("burst_wr_acks", 32'(burst_acks), 32'd8);
    classic(0, 8'h14, 32'h0);
    check("status_full", last_dat, 32'h0002_0008);
    classic(1, 8'h10, 32'h55);
    check("overflow_err", {31'b0, last_err}, 32'd1);
    check("overflow_ack", {31'b0, last_ack}, 32'd0);
    classic(0, 8'h14, 32'h0);
    check("status_still_full", last_dat, 32'h0002_0008);

    // Drain by burst, underflow
    burst(0, 8'h10, 0, 8, 0, 32'h0, 0, 0);
    check("burst_rd_acks", 32'(burst_acks), 32'd8);
    check("burst_rd_n", 32'(burst_rd.size()), 32'd8);
    for (int i = 0; i < burst_rd.size(); i++) check("burst_rd_order", burst_rd[i], 32'h100 + 32'(i));
    classic(0, 8'h14, 32'h0);
    check("status_empty", last_dat, 32'h0001_0000);
    classic(0, 8'h10, 32'h0);
    check("underflow_err", {31'b0, last_err}, 32'd1);
    check("underflow_dat", last_dat, 32'd0);

    // Unmapped mailbox index
    classic(1, 8'h20, 32'h77);
    check("bad_mbox_wr_err", {31'b0, last_err}, 32'd1);
    classic(0, 8'h24, 32'h0);
    check("bad_mbox_rd_err", {31'b0, last_err}, 32'd1);
    classic(0, 8'h04, 32'h0);
    check("mbox0_untouched", last_dat, 32'h0001_0000);

    // Flush
    classic(1, 8'h08, 32'h1);
    for (int i = 0; i < 3; i++) classic(1, 8'h00, 32'hA0 + 32'(i));
    check("irq_three", {30'b0, irq}, 32'd1);
    classic(1, 8'h08, 32'h2);
    check("irq_flushed", {30'b0, irq}, 32'd0);
    classic(0, 8'h04, 32'h0);
    check("status_flushed", last_dat, 32'h0001_0000);
    classic(0, 8'h08, 32'h0);
    check("ctrl_reads", last_dat, 32'd0);

    // Drop statistics
    for (int i = 0; i < DEPTH + 5; i++) classic(1, 8'h00, 32'(i));
    classic(0, 8'h0C, 32'h0);
`ifdef WB_MAILBOX_DROP_STATS_EN
    check("drop_five", last_dat, 32'd5);
`else
    check("drop_absent", last_dat, 32'd0);
`endif
    classic(0, 8'h0C, 32'h0);
    check("drop_cleared", last_dat, 32'd0);
    classic(1, 8'h08, 32'h2);

    // cyc dropped mid-burst: two pushes land
    burst(1, 8'h10, 0, 4, 0, 32'h200, 1, 2);
    classic(0, 8'h14, 32'h0);
    check("cyc_drop_count", last_dat, 32'h0000_0002);
    classic(1, 8'h18, 32'h2);

    // Async reset mid-burst
    classic(1, 8'h18, 32'h1);
    burst(1, 8'h10, 0, 6, 0, 32'h300, 2, 3);
    tick();
    classic(0, 8'h14, 32'h0);
    check("post_reset_status", last_dat, 32'h0001_0000);
    classic(0, 8'h18, 32'h0);
    check("post_reset_ctrl", last_dat, 32'd0);

    // Randomised traffic
    for (int t = 0; t < 300; t++) begin
      logic [7:0]  a;
      logic [31:0] d;
      bit          w;
      a = {4'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 2'b00};
      if ($urandom_range(0, 1) == 1) a[3:2] = 2'b00;
      w = ($urandom_range(0, 1) == 1);
      d = $urandom;
      if (a[3:2] == 2'b10 && $urandom_range(0, 3) != 0) d[1] = 1'b0;
      if ($urandom_range(0, 3) == 0) burst(w, a, $urandom_range(0, 1) == 1,
                                           int'($urandom_range(1, 6)), 1, d, 0, 0);
      else classic(w, a, d);
      if ($urandom_range(0, 4) == 0) tick();
    end

    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_mailbox.md
Name: wb_mailbox

Overview:
- Wishbone B3 slave (responder) placed on the shared interconnect next to main RAM and the UART.
- Gives each of the NUM_CORES mor1kx cores a hardware message FIFO for inter-core messaging.
- Any master may push into any mailbox; the owning core pops its own mailbox and gets a level interrupt while the mailbox is non-empty.
- Supports classic cycles and B3 incrementing bursts with registered feedback.

Parameters:
- NUM_CORES, 1, number of mailboxes, 1..16.
- DEPTH, 8, words per mailbox FIFO, power of two, 2..256.
- AW, 8, significant address bits decoded; must be at least 4+clog2(NUM_CORES).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_ni  in  1  asynchronous active-low reset.
- wb_adr_i  in  AW  byte address; [1:0] ignored.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte selects; ignored, all accesses are full-word.
- wb_we_i, wb_cyc_i, wb_stb_i  in  1 each  standard Wishbone strobes.
- wb_cti_i  in  3  cycle type identifier.
- wb_bte_i  in  2  burst type extension; only linear bursts are supported.
- wb_dat_o  out  32  read data.
- wb_ack_o, wb_err_o, wb_rty_o  out  1 each  termination signals; rty_o is tied to 0.
- irq_o  out  NUM_CORES  bit n = mailbox n non-empty AND irq_en[n].

Behaviour:
- Reset (async assert, sync release):
  - ack_o, err_o, dat_o, irq_o all 0.
  - All FIFOs empty; all irq_en cleared.
- Address decode:
  - reg = adr[3:2]; mbox = adr[AW-1:4].
  - mbox >= NUM_CORES gives err on that beat, with no side effect.
- Register map per mailbox:
  - 0x0 DATA: write pushes, read pops.
  - 0x4 STATUS (RO): [15:0] count, [16] empty, [17] full.
  - 0x8 CTRL: [0] irq_en RW; [1] flush, write-1, self-clearing, reads 0.
  - 0xC DROP: see Optional Feature; reads 0 when the feature is absent.
  - Writes to RO registers are acked and ignored.
- Handshake, registered feedback:
  - A beat is accepted when cyc&stb and the slave is not currently terminating a non-continuing beat.
  - ack or err for that beat asserts the following cycle; dat_o is valid with ack.
- FSM with three states:
  - IDLE: on accept with cti=000 or 111 -> RESP; on accept with cti=010 and bte=00 -> BURST.
  - RESP: one-cycle termination, then IDLE. A new request is not accepted in the termination cycle.
  - BURST: a new beat is accepted in every cycle where stb is high, so terminations come back-to-back.
    - stb low: hold termination low (wait state) and stay in BURST.
    - Accepted beat with cti=111: terminate it, then IDLE.
    - cyc drop: IDLE immediately; the in-flight termination is suppressed, but its side effect has already happened.
  - cti=001 or 011, or bte!=00 with cti=010: treat as classic.
- DATA push when full: err, word dropped, count unchanged.
- DATA pop when empty: err, dat_o=0.
- Push and pop side effects happen exactly once per accepted beat, in the accept cycle. The STATUS count seen by the next beat already reflects them.
- Flush and push to the same mailbox cannot collide, because beats are serialised. Flush empties the FIFO in one cycle.
- Pointer wrap: read/write pointers are clog2(DEPTH)+1 bits. full = MSBs differ and the rest are equal; empty = pointers equal.
- irq_o is combinational from registered state; it updates the cycle after a push, pop or flush.
- err and ack are never asserted together.

Optional Feature:
- Macro: WB_MAILBOX_DROP_STATS_EN.
- Defined:
  - Each mailbox keeps a 16-bit saturating counter of pushes rejected while full.
  - DROP reads return it and clear it in the same beat (clear-on-read).
  - A rejected push in the same cycle as a DROP read counts into the fresh value 1.
- Undefined: counters are absent and DROP reads 0.

Decomposition:
- Package wb_mailbox_pkg:
  - register offsets REG_DATA, REG_STATUS, REG_CTRL, REG_DROP;
  - STATUS and CTRL bit positions;
  - CTI/BTE localparams CTI_CLASSIC, CTI_INC, CTI_EOB, BTE_LINEAR;
  - FSM state enum.
- Sub-module wb_mailbox_fifo, instantiated NUM_CORES times:
  - inputs push/pop/flush and wdata;
  - outputs rdata, count, empty, full.

Test Plan:
- Classic write 0xDEADBEEF to mbox0 DATA, then read STATUS -> ack one cycle after stb, STATUS=0x00000001; irq_o[0] goes 1 only after CTRL is written with 0x1.
- Incrementing burst of 8 writes to mbox1 DATA with DEPTH=8, last beat cti=111 -> 8 consecutive ack cycles, STATUS[17]=1; a 9th classic write -> err, count stays 8.
- Burst read of 8 from mbox1 DATA -> data returned in push order with back-to-back acks, empty=1 afterwards; a 9th read -> err with dat_o=0.
- Access mbox index NUM_CORES (adr=NUM_CORES*16) -> err and no state change; wb_rst_ni pulled low mid-burst -> ack, irq_o and FIFOs cleared asynchronously.
- Fill mbox0 with 3 words, write CTRL=0x2 -> STATUS reads empty, CTRL reads 0, irq_o[0]=0.
- With WB_MAILBOX_DROP_STATS_EN defined: 5 pushes to a full mailbox -> DROP reads 5, then 0 on the next read.
